result_write_arbiter: RTL and testbench



---
 rtl/result_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_result_write_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_write_arbiter.sv
// Round-robin arbiter that writes fixed-length result records from several match
// engines into consecutive result-buffer slots and tracks slot occupancy.
module result_write_arbiter #(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REC_WORDS   = 4,
  parameter int unsigned SLOT_STRIDE = 32'h060E,
  parameter int unsigned BASE_ADDR   = 32'h0000,
  parameter int unsigned NUM_SLOTS   = 16,
  localparam int unsigned SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CNT_W      = $clog2(NUM_SLOTS + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ*REC_WORDS*DATA_W-1:0] rec_data,
  output logic [NUM_REQ-1:0]                  ack,
  output logic                                wr_en,
  output logic [31:0]                         wr_addr,
  output logic [DATA_W-1:0]                   wr_data,
  input  logic                                wr_stall,
  input  logic                                slot_release,
  output logic [CNT_W-1:0]                    slots_used,
  output logic                                full,
  output logic                                rec_done,
  output logic [SRC_W-1:0]                    last_src
);

  localparam int unsigned REC_W  = REC_WORDS * DATA_W;
  localparam int unsigned BEAT_W = (REC_WORDS > 1) ? $clog2(REC_WORDS) : 1;
  localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, WRITE, COMMIT} state_t;

  state_t            state;
  logic [SRC_W-1:0]  ptr;
  logic [SRC_W-1:0]  winner;
  logic [REC_W-1:0]  rec_buf;
  logic [BEAT_W-1:0] beat;
  logic [31:0]       slot_base;
  logic [SLOT_W-1:0] slot_idx;

  logic              rr_found_c;
  logic [SRC_W-1:0]  rr_win_c;
  logic [CNT_W-1:0]  used_nxt_c;
  logic              used_inc_c;
  logic              used_dec_c;

  // Round-robin search starting at the priority pointer.
  always_comb begin
    int unsigned idx;
    rr_found_c = 1'b0;
    rr_win_c   = ptr;
    idx        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!rr_found_c && req[idx]) begin
        rr_found_c = 1'b1;
        rr_win_c   = SRC_W'(idx);
      end
    end
  end

  // Occupancy: a release with nothing committed is ignored; release + commit cancel.
  always_comb begin
    used_inc_c = (state == COMMIT);
    used_dec_c = slot_release && (slots_used != '0);
    used_nxt_c = slots_used;
    if (used_inc_c && !used_dec_c)
      used_nxt_c = slots_used + CNT_W'(1);
    else if (!used_inc_c && used_dec_c)
      used_nxt_c = slots_used - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      winner     <= '0;
      rec_buf    <= '0;
      beat       <= '0;
      slot_base  <= 32'(BASE_ADDR);
      slot_idx   <= '0;
      ack        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      slots_used <= '0;
      full       <= 1'b0;
      rec_done   <= 1'b0;
      last_src   <= '0;
    end else begin
      ack        <= '0;
      rec_done   <= 1'b0;
      slots_used <= used_nxt_c;
      full       <= (used_nxt_c == CNT_W'(NUM_SLOTS));
      case (state)
        IDLE: begin
          if (rr_found_c && !full) begin
            winner        <= rr_win_c;
            ack[rr_win_c] <= 1'b1;
            state         <= GRANT;
          end
        end
        GRANT: begin
          rec_buf <= rec_data[32'(winner) * REC_W +: REC_W];
          beat    <= '0;
          wr_en   <= 1'b1;
          wr_addr <= slot_base;
          wr_data <= rec_data[32'(winner) * REC_W +: DATA_W];
          state   <= WRITE;
        end
        WRITE: begin
          if (!wr_stall) begin
            if (beat == BEAT_W'(REC_WORDS - 1)) begin
              wr_en    <= 1'b0;
              rec_done <= 1'b1;
              last_src <= winner;
              state    <= COMMIT;
            end else begin
              beat    <= beat + BEAT_W'(1);
              wr_addr <= wr_addr + 32'd4;
              wr_data <= rec_buf[(32'(beat) + 32'd1) * DATA_W +: DATA_W];
            end
          end
        end
        COMMIT: begin
          ptr <= (winner == SRC_W'(NUM_REQ - 1)) ? '0 : winner + SRC_W'(1);
          if (slot_idx == SLOT_W'(NUM_SLOTS - 1)) begin
            slot_idx  <= '0;
            slot_base <= 32'(BASE_ADDR);
          end else begin
            slot_idx  <= slot_idx + SLOT_W'(1);
            slot_base <= slot_base + 32'(SLOT_STRIDE);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_write_arbiter.sv
// Directed bench for result_write_arbiter: reset, single record, round-robin,
// stall, full/wrap, release-at-commit and mid-write reset.
module tb_result_write_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned DW   = 32;
  localparam int unsigned RW   = 4;
  localparam int unsigned NSL  = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*RW*DW-1:0]  rec_data;
  logic [NREQ-1:0]        ack;
  logic                   wr_en;
  logic [31:0]            wr_addr;
  logic [DW-1:0]          wr_data;
  logic                   wr_stall;
  logic                   slot_release;
  logic [2:0]             slots_used;
  logic                   full;
  logic                   rec_done;
  logic [1:0]             last_src;

  int total = 0;
  int bad   = 0;

  result_write_arbiter #(
    .NUM_REQ(NREQ), .DATA_W(DW), .REC_WORDS(RW),
    .SLOT_STRIDE(32'h060E), .BASE_ADDR(32'h0000), .NUM_SLOTS(NSL)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .rec_data(rec_data), .ack(ack),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_stall(wr_stall),
    .slot_release(slot_release), .slots_used(slots_used), .full(full),
    .rec_done(rec_done), .last_src(last_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] w0_of(input int src);
    case (src)
      0:       return 32'h0000_0010;
      1:       return 32'h0000_00A0;
      default: return 32'h0000_00C0;
    endcase
  endfunction

  task automatic set_words(input int src, input logic [31:0] w0);
    for (int b = 0; b < RW; b++)
      rec_data[(src * RW + b) * DW +: DW] = w0 + 32'(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Bounded wait for the grant pulse, then compare the one-hot ack.
  task automatic wait_ack(input string tag, input logic [2:0] exp);
    int n = 0;
    while (ack == '0 && n < 12) begin
      tick();
      n++;
    end
    check(tag, 64'(ack), 64'(exp));
  endtask

  // Entered on the cycle ack is visible; follows the record through COMMIT into IDLE.
  task automatic run_rec(input string tag, input int src, input logic [31:0] base,
                         input int stall_beat, input int stall_n, input bit rel_commit,
                         input logic [2:0] exp_used);
    logic [31:0] w0;
    w0 = w0_of(src);
    req[src] = 1'b0;
    tick();
    check({tag, "_ack_pulse"}, 64'(ack), 64'd0);
    set_words(src, 32'hDEAD_0000);
    for (int b = 0; b < RW; b++) begin
      check({tag, "_wr_en"}, 64'(wr_en), 64'd1);
      check({tag, "_addr"}, 64'(wr_addr), 64'(base + 32'(4 * b)));
      check({tag, "_data"}, 64'(wr_data), 64'(w0 + 32'(b)));
      if (b == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          wr_stall = 1'b1;
          tick();
          check({tag, "_hold_addr"}, 64'(wr_addr), 64'(base + 32'(4 * b)));
          check({tag, "_hold_data"}, 64'(wr_data), 64'(w0 + 32'(b)));
          check({tag, "_hold_done"}, 64'(rec_done), 64'd0);
        end
        wr_stall = 1'b0;
      end
      tick();
    end
    check({tag, "_rec_done"}, 64'(rec_done), 64'd1);
    check({tag, "_wr_idle"}, 64'(wr_en), 64'd0);
    check({tag, "_last_src"}, 64'(last_src), 64'(src));
    if (rel_commit) slot_release = 1'b1;
    tick();
    slot_release = 1'b0;
    check({tag, "_done_pulse"}, 64'(rec_done), 64'd0);
    check({tag, "_slots_used"}, 64'(slots_used), 64'(exp_used));
    set_words(src, w0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rr_base [4];
    int          rr_src  [4];
    int          seen;

    rr_base = '{32'h0000, 32'h060E, 32'h0C1C, 32'h122A};
    rr_src  = '{0, 1, 2, 0};

    rst = 1'b1; req = 3'b111; rec_data = '0; wr_stall = 1'b0; slot_release = 1'b0;
    for (int i = 0; i < NREQ; i++) set_words(i, w0_of(i));

    // Reset held two cycles with all requests pending.
    tick();
    tick();
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_rec_done", 64'(rec_done), 64'd0);
    check("rst_slots_used", 64'(slots_used), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_last_src", 64'(last_src), 64'd0);
    rst = 1'b0;
    tick();
    check("rst_first_ack", 64'(ack), 64'd1);

    // Single record from requester 1, then requester 0 goes to the next slot.
    do_reset();
    req = 3'b010;
    wait_ack("single_ack", 3'b010);
    run_rec("single", 1, 32'h0000, -1, 0, 1'b0, 3'd1);
    req = 3'b001;
    wait_ack("next_ack", 3'b001);
    run_rec("next", 0, 32'h060E, -1, 0, 1'b0, 3'd2);

    // Round-robin with all requests held, filling all four slots.
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_ack("rr_ack", 3'(1 << rr_src[i]));
      run_rec("rr", rr_src[i], rr_base[i], -1, 0, 1'b0, 3'(i + 1));
      req = 3'b111;
    end
    check("full_set", 64'(full), 64'd1);
    seen = 0;
    repeat (6) begin
      tick();
      if (ack != '0) seen = 1;
    end
    check("full_no_ack", 64'(seen), 64'd0);
    slot_release = 1'b1;
    tick();
    slot_release = 1'b0;
    check("release_used", 64'(slots_used), 64'd3);
    check("release_full", 64'(full), 64'd0);
    check("release_no_same_cycle_grant", 64'(ack), 64'd0);
    tick();
    check("wrap_ack", 64'(ack), 64'b010);
    run_rec("wrap", 1, 32'h0000, -1, 0, 1'b0, 3'd4);
    check("wrap_full", 64'(full), 64'd1);

    // Stall on beat 2 for three cycles.
    do_reset();
    req = 3'b100;
    wait_ack("stall_ack", 3'b100);
    run_rec("stall", 2, 32'h0000, 2, 3, 1'b0, 3'd1);

    // Release coincides with COMMIT: occupancy unchanged.
    req = 3'b001;
    wait_ack("relc_ack", 3'b001);
    run_rec("relc", 0, 32'h060E, -1, 0, 1'b1, 3'd1);

    // Reset during beat 1 aborts the record; next record restarts at slot 0.
    do_reset();
    req = 3'b010;
    wait_ack("abort_ack", 3'b010);
    tick();
    check("abort_beat0_addr", 64'(wr_addr), 64'h0000);
    tick();
    check("abort_beat1_addr", 64'(wr_addr), 64'h0004);
    rst = 1'b1;
    tick();
    check("abort_wr_en", 64'(wr_en), 64'd0);
    check("abort_rec_done", 64'(rec_done), 64'd0);
    check("abort_slots_used", 64'(slots_used), 64'd0);
    rst = 1'b0;
    wait_ack("after_rst_ack", 3'b010);
    run_rec("after_rst", 1, 32'h0000, -1, 0, 1'b0, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
